// File: rtl/get_extreme_seq.sv
// Sequential argmin/argmax over NUM packed unsigned channels, one channel per clock.
// Define GET_EXTREME_TIE_LOW_EN to resolve ties to the lowest index (default: highest).
module get_extreme_seq #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned NUM   = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [NUM*WIDTH-1:0]   nums,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       idx,
  output logic [WIDTH-1:0]       val
);

  localparam int unsigned SNAP_W = NUM * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic              mode_q, mode_d;
  logic [WIDTH-1:0]  best_val_q, best_val_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  val_q, val_d;

  logic [WIDTH-1:0]  cand_c;
  logic              take_c;
  logic [WIDTH-1:0]  win_val_c;
  logic [IDX_W-1:0]  win_idx_c;

  assign cand_c = snap_q[32'(cnt_q) * WIDTH +: WIDTH];

  // Candidate replaces the running best when strictly better, or on a tie unless tie-low.
`ifdef GET_EXTREME_TIE_LOW_EN
  assign take_c = mode_q ? (cand_c > best_val_q) : (cand_c < best_val_q);
`else
  assign take_c = mode_q ? (cand_c >= best_val_q) : (cand_c <= best_val_q);
`endif

  assign win_val_c = take_c ? cand_c : best_val_q;
  assign win_idx_c = take_c ? cnt_q  : best_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      mode_q     <= 1'b0;
      best_val_q <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      val_q      <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      mode_q     <= mode_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      val_q      <= val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    mode_d     = mode_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    idx_d      = idx_q;
    val_d      = val_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d     = nums;
          mode_d     = mode;
          best_val_d = nums[WIDTH-1:0];
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
          if (NUM == 1) begin
            idx_d  = '0;
            val_d  = nums[WIDTH-1:0];
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        best_val_d = win_val_c;
        best_idx_d = win_idx_c;
        cnt_d      = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          idx_d   = win_idx_c;
          val_d   = win_val_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign idx  = idx_q;
  assign val  = val_q;

endmodule

// File: tb/tb_get_extreme_seq.sv
// Randomised + directed bench for get_extreme_seq against a behavioural argmin/argmax model.
module tb_get_extreme_seq;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned NUM   = 4;
  localparam int unsigned IDX_W = 2;
`ifdef GET_EXTREME_TIE_LOW_EN
  localparam bit TIE_LOW = 1'b1;
`else
  localparam bit TIE_LOW = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start = 1'b0;
  logic                 mode = 1'b0;
  logic [NUM*WIDTH-1:0] nums = '0;
  logic                 busy, done;
  logic [IDX_W-1:0]     idx;
  logic [WIDTH-1:0]     val;

  logic                 start1 = 1'b0;
  logic [7:0]           nums1 = '0;
  logic                 busy1, done1;
  logic [0:0]           idx1;
  logic [7:0]           val1;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;
  bit busy1_seen = 1'b0;

  always #5 clk = ~clk;

  get_extreme_seq #(.WIDTH(WIDTH), .NUM(NUM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .nums(nums),
    .busy(busy), .done(done), .idx(idx), .val(val)
  );

  get_extreme_seq #(.WIDTH(8), .NUM(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(1'b0), .nums(nums1),
    .busy(busy1), .done(done1), .idx(idx1), .val(val1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Extreme value over all channels, then the tie rule picks which index holds it.
  function automatic int ref_val(input logic [NUM*WIDTH-1:0] v, input logic md);
    int best = int'(v[WIDTH-1:0]);
    for (int i = 1; i < NUM; i++) begin
      int c = int'(v[i*WIDTH +: WIDTH]);
      if (md ? (c > best) : (c < best)) best = c;
    end
    return best;
  endfunction

  function automatic int ref_idx(input logic [NUM*WIDTH-1:0] v, input logic md);
    int e = ref_val(v, md);
    int r = -1;
    for (int i = 0; i < NUM; i++) begin
      if (int'(v[i*WIDTH +: WIDTH]) == e) begin
        if (!TIE_LOW || r < 0) r = i;
      end
    end
    return r;
  endfunction

  // Cycle-level model: a request yields its result NUM-1 edges after acceptance.
  int m_rem = 0;
  int m_busy = 0, m_done = 0, m_idx = 0, m_val = 0;
  int r_idx = 0, r_val = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_busy <= 0; m_done <= 0; m_idx <= 0; m_val <= 0;
    end else begin
      m_done <= 0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1; m_busy <= 0; m_idx <= r_idx; m_val <= r_val;
        end
      end else if (start) begin
        m_rem  <= NUM - 1;
        m_busy <= 1;
        r_idx  <= ref_idx(nums, mode);
        r_val  <= ref_val(nums, mode);
      end
    end
  end

  always @(negedge clk) begin
    if (busy1) busy1_seen <= 1'b1;
    if (run_chk) begin
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
      chk("idx",  int'(idx),  m_idx);
      chk("val",  int'(val),  m_val);
    end
  end

  task automatic pulse_start(input logic [NUM*WIDTH-1:0] v, input logic md);
    @(posedge clk); #2;
    nums = v; mode = md; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Entered just after the edge that accepted start; lat counts edges until done.
  task automatic wait_done(input bit disturb, output int lat, output int bc);
    bit got = 1'b0;
    lat = 0; bc = 0;
    if (disturb) begin
      nums[NUM*WIDTH-1 -: WIDTH] = 3'd7;
      start = 1'b1;
    end
    while (!got && lat < 20) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (busy) bc++;
        @(posedge clk); #2;
        start = 1'b0;
        lat++;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int lat, bc, n;
    #1 rst_n = 1'b0;
    #20;
    run_chk = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_idx",  int'(idx),  0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Min search
    pulse_start({3'd5, 3'd1, 3'd6, 3'd3}, 1'b0);
    wait_done(1'b0, lat, bc);
    chk("min_lat", lat, 3);
    chk("min_busy_cycles", bc, 3);
    chk("min_idx", int'(idx), 2);
    chk("min_val", int'(val), 1);

    // Reset mid-scan after one SCAN edge
    pulse_start({3'd4, 3'd2, 3'd6, 3'd5}, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx",  int'(idx),  0);
    chk("rst_val",  int'(val),  0);
    @(posedge clk); #2 rst_n = 1'b1;
    count_done(10, n);
    chk("rst_no_done", n, 0);

    // Max with tie
    pulse_start({3'd4, 3'd7, 3'd2, 3'd7}, 1'b1);
    wait_done(1'b0, lat, bc);
    chk("maxtie_idx", int'(idx), TIE_LOW ? 0 : 2);
    chk("maxtie_val", int'(val), 7);

    // All equal, min
    pulse_start({4{3'd3}}, 1'b0);
    wait_done(1'b0, lat, bc);
    chk("alleq_idx", int'(idx), TIE_LOW ? 0 : 3);
    chk("alleq_val", int'(val), 3);

    // Snapshot and ignored start while busy
    pulse_start({3'd0, 3'd4, 3'd4, 3'd4}, 1'b0);
    wait_done(1'b1, lat, bc);
    chk("snap_idx", int'(idx), 3);
    chk("snap_val", int'(val), 0);
    start = 1'b0;
    count_done(8, n);
    chk("snap_no_second_done", n, 0);

    // Back-to-back: start on the edge right after done
    pulse_start({3'd1, 3'd5, 3'd2, 3'd6}, 1'b0);
    wait_done(1'b0, lat, bc);
    chk("b2b_first_idx", int'(idx), 3);
    nums = {3'd2, 3'd6, 3'd0, 3'd7}; mode = 1'b1; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(1'b0, lat, bc);
    chk("b2b_gap", lat + 1, 4);
    chk("b2b_idx", int'(idx), 0);
    chk("b2b_val", int'(val), 7);

    // NUM=1 instance
    @(posedge clk); #2 nums1 = 8'hA5; start1 = 1'b1;
    @(posedge clk); #2 start1 = 1'b0;
    @(negedge clk);
    chk("n1_done", int'(done1), 1);
    chk("n1_idx",  int'(idx1),  0);
    chk("n1_val",  int'(val1),  8'hA5);
    @(negedge clk);
    chk("n1_done_pulse", int'(done1), 0);

    // Randomised phase, including tie-prone values and occasional resets
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      rst_n = ($urandom_range(0, 79) != 0);
      start = ($urandom_range(0, 2) != 0);
      mode  = 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM; i++) begin
        if ($urandom_range(0, 1) == 0) nums[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 7));
        else nums[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(6, 7));
      end
    end
    @(posedge clk); #2 rst_n = 1'b1; start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("n1_busy_never", int'(busy1_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
